// File: rtl/ysyx_2022040010_wb_ctrl_pkg.sv
// Shared definitions for the writeback controller: register file geometry,
// common constants and the load size encoding.
package ysyx_2022040010_wb_ctrl_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef logic [XLEN-1:0] reg_bus_t;
    typedef logic [AW-1:0]   reg_addr_t;

    localparam int       REG_NUM      = NREG;
    localparam reg_bus_t ZERO_WORD    = '0;
    localparam logic     WRITE_ENABLE = 1'b1;

    // Load access size as presented on lsu_size.
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

endpackage

// File: rtl/ysyx_2022040010_wb_ctrl_if.sv
// Bundle of all result, issue, scoreboard and register-file write signals.
// Handshake rule for both result channels: a transfer happens on a rising
// clk edge where valid && ready are both high; the producer keeps its
// payload stable while valid is high and ready is low.
interface ysyx_2022040010_wb_ctrl_if;
    import ysyx_2022040010_wb_ctrl_pkg::*;

    logic      alu_valid;
    logic      alu_ready;
    logic      alu_wen;
    reg_addr_t alu_rd;
    reg_bus_t  alu_data;

    logic      lsu_valid;
    logic      lsu_ready;
    reg_addr_t lsu_rd;
    logic [1:0] lsu_size;
    logic      lsu_signed;
    reg_bus_t  lsu_data;

    logic      iss_valid;
    reg_addr_t iss_rd;
    logic      iss_ready;

    reg_addr_t chk_rs1;
    reg_addr_t chk_rs2;
    logic      rs1_busy;
    logic      rs2_busy;

    logic      rf_we;
    reg_addr_t rf_waddr;
    reg_bus_t  rf_wdata;
    logic [63:0] wb_count;

    // Producer / decode / register-file side.
    modport master (
        output alu_valid, alu_wen, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_size, lsu_signed, lsu_data,
        output iss_valid, iss_rd, chk_rs1, chk_rs2,
        input  alu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy,
        input  rf_we, rf_waddr, rf_wdata, wb_count
    );

    // Writeback controller side.
    modport slave (
        input  alu_valid, alu_wen, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_size, lsu_signed, lsu_data,
        input  iss_valid, iss_rd, chk_rs1, chk_rs2,
        output alu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy,
        output rf_we, rf_waddr, rf_wdata, wb_count
    );

endinterface

// File: rtl/ysyx_2022040010_load_ext.sv
// Load data extension: picks the byte/half/word from the low bits of the raw
// load data and sign- or zero-extends it to the full register width.
module ysyx_2022040010_load_ext
    import ysyx_2022040010_wb_ctrl_pkg::*;
(
    input  logic [1:0] size,
    input  logic       sext,
    input  reg_bus_t   raw,
    output reg_bus_t   data
);

    // Select width and fill the upper bits with the sign or with zeros.
    always_comb begin
        data = raw;
        case (size)
            SZ_B:    data = {{(XLEN-8){sext & raw[7]}}, raw[7:0]};
            SZ_H:    data = {{(XLEN-16){sext & raw[15]}}, raw[15:0]};
            SZ_W:    data = {{(XLEN-32){sext & raw[31]}}, raw[31:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/ysyx_2022040010_wb_ctrl.sv
// Writeback controller: arbitrates ALU and load results onto the single
// register file write port, keeps a pending-load scoreboard for decode and
// counts committed register writes.
module ysyx_2022040010_wb_ctrl
    import ysyx_2022040010_wb_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    ysyx_2022040010_wb_ctrl_if.slave bus
);

    logic            alu_fire;
    logic            lsu_fire;
    logic            commit;
    reg_bus_t        lsu_ext;
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pend_set;
    logic [NREG-1:0] pend_clr;
    logic            rf_we_q;
    reg_addr_t       rf_waddr_q;
    reg_bus_t        rf_wdata_q;
    logic [63:0]     wb_count_q;

    // The LSU holds the older instruction, so it always wins the write port.
    assign bus.lsu_ready = !rst;
    assign bus.alu_ready = !rst && !bus.lsu_valid;
    assign lsu_fire      = bus.lsu_valid && bus.lsu_ready;
    assign alu_fire      = bus.alu_valid && bus.alu_ready;

    // Bit 0 of the scoreboard is never set, so x0 always reads not-busy.
    assign bus.iss_ready = !rst && !pending_q[bus.iss_rd];
    assign bus.rs1_busy  = !rst && pending_q[bus.chk_rs1];
    assign bus.rs2_busy  = !rst && pending_q[bus.chk_rs2];

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.wb_count = wb_count_q;

    ysyx_2022040010_load_ext u_load_ext (
        .size (bus.lsu_size),
        .sext (bus.lsu_signed),
        .raw  (bus.lsu_data),
        .data (lsu_ext)
    );

    // Decide whether the accepted result (if any) really writes a register.
    always_comb begin
        commit = 1'b0;
        if (lsu_fire) begin
            commit = (bus.lsu_rd != '0);
        end else if (alu_fire) begin
            commit = bus.alu_wen && (bus.alu_rd != '0);
        end
    end

    // Scoreboard update masks; applying set after clear makes set win.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (lsu_fire) begin
            pend_clr[bus.lsu_rd] = 1'b1;
        end
        if (bus.iss_valid && bus.iss_ready && (bus.iss_rd != '0)) begin
            pend_set[bus.iss_rd] = 1'b1;
        end
    end

    // Pending-load scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~pend_clr) | pend_set;
        end
    end

    // Registered write port and commit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= ZERO_WORD;
            wb_count_q <= '0;
        end else begin
            rf_we_q <= commit ? WRITE_ENABLE : 1'b0;
            if (lsu_fire) begin
                rf_waddr_q <= bus.lsu_rd;
                rf_wdata_q <= lsu_ext;
            end else if (alu_fire) begin
                rf_waddr_q <= bus.alu_rd;
                rf_wdata_q <= bus.alu_data;
            end
            if (commit) begin
                wb_count_q <= wb_count_q + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_2022040010_wb_ctrl.sv
// Self-checking bench for the writeback controller: directed steps followed
// by randomized traffic, all compared against a behavioural model.
module tb_ysyx_2022040010_wb_ctrl;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    ysyx_2022040010_wb_ctrl_if bus ();

    ysyx_2022040010_wb_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Behavioural model state.
    logic        m_pend [32];
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [63:0] m_wdata;
    logic [63:0] m_count;

    function automatic logic [63:0] model_ext(logic [1:0] size, logic sext, logic [63:0] raw);
        int          bits;
        logic [63:0] mask;
        logic [63:0] v;
        if (size == 2'd3) return raw;
        bits = 8 << size;
        mask = (64'd1 << bits) - 64'd1;
        v = raw & mask;
        if (sext && raw[bits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        bus.alu_valid  = 1'b0;
        bus.alu_wen    = 1'b0;
        bus.alu_rd     = '0;
        bus.alu_data   = '0;
        bus.lsu_valid  = 1'b0;
        bus.lsu_rd     = '0;
        bus.lsu_size   = '0;
        bus.lsu_signed = 1'b0;
        bus.lsu_data   = '0;
        bus.iss_valid  = 1'b0;
        bus.iss_rd     = '0;
        bus.chk_rs1    = '0;
        bus.chk_rs2    = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_advance();
        logic old_pend [32];
        logic lsu_acc;
        logic alu_acc;
        logic iss_ok;
        old_pend = m_pend;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
            m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_count = '0;
            return;
        end
        lsu_acc = bus.lsu_valid;
        alu_acc = bus.alu_valid && !bus.lsu_valid;
        iss_ok  = bus.iss_valid && !old_pend[bus.iss_rd];
        if (lsu_acc) begin
            m_waddr = bus.lsu_rd;
            m_wdata = model_ext(bus.lsu_size, bus.lsu_signed, bus.lsu_data);
            m_we    = (bus.lsu_rd != 0);
        end else if (alu_acc) begin
            m_waddr = bus.alu_rd;
            m_wdata = bus.alu_data;
            m_we    = bus.alu_wen && (bus.alu_rd != 0);
        end else begin
            m_we = 1'b0;
        end
        if (m_we) m_count = m_count + 64'd1;
        if (lsu_acc) m_pend[bus.lsu_rd] = 1'b0;
        if (iss_ok && bus.iss_rd != 0) m_pend[bus.iss_rd] = 1'b1;
    endtask

    // One cycle: check combinational outputs, clock, check registered outputs.
    task automatic step();
        #1;
        check("lsu_ready", 64'(bus.lsu_ready), 64'(!rst));
        check("alu_ready", 64'(bus.alu_ready), 64'(!rst && !bus.lsu_valid));
        check("iss_ready", 64'(bus.iss_ready), 64'(!rst && !m_pend[bus.iss_rd]));
        check("rs1_busy", 64'(bus.rs1_busy), 64'(!rst && m_pend[bus.chk_rs1]));
        check("rs2_busy", 64'(bus.rs2_busy), 64'(!rst && m_pend[bus.chk_rs2]));
        model_advance();
        @(posedge clk);
        @(negedge clk);
        check("rf_we", 64'(bus.rf_we), 64'(m_we));
        check("rf_waddr", 64'(bus.rf_waddr), 64'(m_waddr));
        check("rf_wdata", bus.rf_wdata, m_wdata);
        check("wb_count", bus.wb_count, m_count);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_count = '0;
        rst = 1'b1;
        set_idle();

        // Reset.
        step();
        step();
        rst = 1'b0;

        // ALU write rd=5.
        bus.alu_valid = 1'b1; bus.alu_wen = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 64'h1234;
        step();
        check("alu_rd5_wdata", bus.rf_wdata, 64'h1234);
        check("alu_rd5_count", bus.wb_count, 64'd1);
        set_idle();

        // Load extension cases.
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd6; bus.lsu_size = 2'd0; bus.lsu_signed = 1'b1;
        bus.lsu_data = 64'h80;
        step();
        check("lb_sext", bus.rf_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        bus.lsu_signed = 1'b0;
        step();
        check("lbu_zext", bus.rf_wdata, 64'h80);
        bus.lsu_size = 2'd2; bus.lsu_signed = 1'b1; bus.lsu_data = 64'h8000_0000;
        step();
        check("lw_sext", bus.rf_wdata, 64'hFFFF_FFFF_8000_0000);
        bus.lsu_size = 2'd1; bus.lsu_data = 64'hABCD_0000_0000_7FFF;
        step();
        bus.lsu_size = 2'd3;
        step();
        set_idle();

        // Simultaneous ALU (rd=3) and LSU (rd=7).
        bus.alu_valid = 1'b1; bus.alu_wen = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 64'h3333;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_size = 2'd3; bus.lsu_data = 64'h7777;
        step();
        check("both_first_addr", 64'(bus.rf_waddr), 64'd7);
        bus.lsu_valid = 1'b0;
        step();
        check("both_second_addr", 64'(bus.rf_waddr), 64'd3);
        set_idle();

        // Scoreboard on rd=9.
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9; bus.chk_rs1 = 5'd9;
        step();
        step();                    // second issue sees iss_ready=0
        bus.iss_valid = 1'b0;
        step();
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_size = 2'd3; bus.lsu_data = 64'h99;
        step();
        bus.lsu_valid = 1'b0;
        step();                    // busy now 0
        bus.iss_valid = 1'b1; bus.lsu_valid = 1'b1;
        step();                    // issue and return together: set wins
        bus.iss_valid = 1'b0; bus.lsu_valid = 1'b0;
        step();

        // rd=0 writes and issues.
        bus.alu_valid = 1'b1; bus.alu_wen = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 64'hDEAD;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd0; bus.chk_rs2 = 5'd0;
        step();
        bus.alu_valid = 1'b0; bus.iss_valid = 1'b0;
        step();

        // Reset with pending bits set and a write in progress.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 64'h4444;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd12; bus.chk_rs2 = 5'd12;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_idle();
        bus.chk_rs1 = 5'd9; bus.chk_rs2 = 5'd12; bus.iss_rd = 5'd9;
        step();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rst            = ($urandom_range(0, 63) == 0);
            bus.alu_valid  = $urandom_range(0, 1);
            bus.alu_wen    = ($urandom_range(0, 3) != 0);
            bus.alu_rd     = 5'($urandom_range(0, 7));
            bus.alu_data   = {$urandom, $urandom};
            bus.lsu_valid  = ($urandom_range(0, 2) == 0);
            bus.lsu_rd     = 5'($urandom_range(0, 7));
            bus.lsu_size   = 2'($urandom_range(0, 3));
            bus.lsu_signed = $urandom_range(0, 1);
            bus.lsu_data   = {$urandom, $urandom};
            bus.iss_valid  = $urandom_range(0, 1);
            bus.iss_rd     = 5'($urandom_range(0, 7));
            bus.chk_rs1    = 5'($urandom_range(0, 7));
            bus.chk_rs2    = 5'($urandom_range(0, 31));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
